alu_arbiter: RTL and testbench

Shares the single combinational ALU between NREQ requesters, for example the EX stage and a multi-cycle helper unit. Arbitrates with a round-robin pointer and captures the winner's operands into registers that drive the ALU. Registers the ALU result and returns it to the winner through a valid/ready response channel tagged with the requester index. Sits between the requesters and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among NREQ requesters with registered operands and result.
// Optional macro ALU_ARB_FIXED_PRIO_EN: lowest-index-wins arbitration, no rotation pointer.
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int W    = 32,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*4-1:0] req_op,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [3:0]        alu_op,
    input  logic [W-1:0]      alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           accept_win;
    logic           grant_vld;
    logic           handshake;
    logic [IDW-1:0] grant_idx;
    logic [W-1:0]   win_a, win_b;
    logic [3:0]     win_op;

    logic [W-1:0]   alu_a_q, alu_b_q;
    logic [3:0]     alu_op_q;
    logic [IDW-1:0] id_q;
    logic           err_q;
    logic           rsp_valid_q;
    logic [W-1:0]   rsp_data_q;
    logic [IDW-1:0] rsp_id_q;
    logic           rsp_err_q;

    function automatic logic op_illegal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b1000, 4'b0001, 4'b0101, 4'b1101,
            4'b0010, 4'b0011, 4'b0111, 4'b0110, 4'b0100: return 1'b0;
            default:                                     return 1'b1;
        endcase
    endfunction

    // Gated by rst_n so no handshake can be signalled while reset is held.
    assign accept_win = rst_n && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    assign handshake  = accept_win && grant_vld;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] rr_ptr_q;
    int             cand;

    // Walk the search order backwards so the first hit after rr_ptr_q is the last one written.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(rr_ptr_q) + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if ((i == cand) && req_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = IDW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= IDW'(NREQ - 1);
        end else if (handshake) begin
            rr_ptr_q <= grant_idx;
        end
    end
`endif

    always_comb begin
        win_a  = '0;
        win_b  = '0;
        win_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                win_a  = req_a[i*W +: W];
                win_b  = req_b[i*W +: W];
                win_op = req_op[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (handshake) state_d = EXEC;
            EXEC: state_d = RESP;
            RESP: begin
                if (handshake) begin
                    state_d = EXEC;
                end else if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = handshake && (grant_idx == IDW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= 4'b0000;
            id_q        <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (handshake) begin
                alu_a_q  <= win_a;
                alu_b_q  <= win_b;
                alu_op_q <= win_op;
                id_q     <= grant_idx;
                err_q    <= op_illegal(win_op);
            end
            // A back-to-back accept in RESP keeps rsp_valid high straight into EXEC.
            if (state_q == EXEC) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= err_q ? '0 : alu_out;
                rsp_id_q    <= id_q;
                rsp_err_q   <= err_q;
            end else if ((state_q == RESP) && rsp_ready && !handshake) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vectors, corner sequences and a randomized model run.
module tb_alu_arbiter;
    localparam int NREQ = 2;
    localparam int W    = 32;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*4-1:0] req_op;
    logic [W-1:0]      alu_a, alu_b, alu_out, rsp_data;
    logic [3:0]        alu_op;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [IDW-1:0]    rsp_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    logic [3:0] legal_ops [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0101, 4'b1101,
                                   4'b0010, 4'b0011, 4'b0111, 4'b0110, 4'b0100};

    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [3:0] op);
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0101: return a >> b[4:0];
            4'b1101: return W'($signed(a) >>> b[4:0]);
            4'b0010: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'b0011: return (a < b) ? W'(1) : W'(0);
            4'b0111: return a & b;
            4'b0110: return a | b;
            4'b0100: return a ^ b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        logic hit = 1'b0;
        foreach (legal_ops[k]) if (legal_ops[k] == op) hit = 1'b1;
        return hit;
    endfunction

    // Stand-in for the shared ALU the arbiter drives.
    always_comb alu_out = alu_fn(alu_a, alu_b, alu_op);

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] op);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_op[id*4 +: 4] = op;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated request from start to consumed response; entered and left just after a rising edge.
    task automatic do_single(input string tag, input int id, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [3:0] op,
                             input logic [W-1:0] exp_d, input logic exp_e);
        logic [NREQ-1:0] mask;
        int n;
        mask = NREQ'(1) << id;
        rsp_ready = 1'b0;
        set_ops(id, a, b, op);
        req_valid = mask;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_grant"}, W'(req_ready), W'(mask));
        tick();
        req_valid = '0;
        @(negedge clk);
        chk({tag, "_exec_valid"}, W'(rsp_valid), 0);
        chk({tag, "_alu_a"}, alu_a, a);
        chk({tag, "_alu_b"}, alu_b, b);
        chk({tag, "_alu_op"}, W'(alu_op), W'(op));
        tick();
        @(negedge clk);
        chk({tag, "_rsp_valid"}, W'(rsp_valid), 1);
        chk({tag, "_rsp_data"}, rsp_data, exp_d);
        chk({tag, "_rsp_id"}, W'(rsp_id), W'(id));
        chk({tag, "_rsp_err"}, W'(rsp_err), W'(exp_e));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_valid"}, W'(rsp_valid), 0);
        tick();
    endtask

    typedef struct {
        int         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0] op;
        logic [W-1:0] exp_d;
        logic       exp_e;
    } vec_t;

    vec_t vt [13];

    // Transaction-level reference: an op in flight, a response held, and the last winner.
    logic            m_exec, m_hold, m_vld;
    int              m_last;
    logic [NREQ-1:0] m_acc;
    logic [W-1:0]    m_ca, m_cb, m_data;
    logic [3:0]      m_cop;
    int              m_cid, m_id;
    logic            m_cerr, m_err;

    task automatic model_step();
        logic win;
        int g;
        int c;
        logic [NREQ-1:0] exp_ready;
        win = !m_exec && (!m_hold || rsp_ready);
        g = -1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && req_valid[k]) g = k;
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            c = (m_last + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (g < 0 && i == c && req_valid[i]) g = i;
            end
        end
`endif
        exp_ready = (win && g >= 0) ? (NREQ'(1) << g) : '0;
        chk("rnd_req_ready", W'(req_ready), W'(exp_ready));
        chk("rnd_rsp_valid", W'(rsp_valid), W'(m_vld));
        if (m_hold) begin
            chk("rnd_rsp_data", rsp_data, m_data);
            chk("rnd_rsp_id", W'(rsp_id), W'(m_id));
            chk("rnd_rsp_err", W'(rsp_err), W'(m_err));
        end
        if (m_exec) begin
            chk("rnd_alu_a", alu_a, m_ca);
            chk("rnd_alu_op", W'(alu_op), W'(m_cop));
        end
        m_acc = exp_ready;
        if (m_exec) begin
            m_exec = 1'b0;
            m_hold = 1'b1;
            m_vld  = 1'b1;
            m_data = m_cerr ? '0 : alu_fn(m_ca, m_cb, m_cop);
            m_id   = m_cid;
            m_err  = m_cerr;
        end else if (win && g >= 0) begin
            m_ca   = req_a[g*W +: W];
            m_cb   = req_b[g*W +: W];
            m_cop  = req_op[g*4 +: 4];
            m_cerr = !is_legal(m_cop);
            m_cid  = g;
            m_exec = 1'b1;
            m_hold = 1'b0;
            m_last = g;
        end else if (m_hold && rsp_ready) begin
            m_hold = 1'b0;
            m_vld  = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got_g [6];
        int exp_g [6];
        int n_g;
        logic [NREQ-1:0] rv;

        vt[0]  = '{0, 32'h0000006A, 32'h00000004, 4'b0000, 32'h0000006E, 1'b0};
        vt[1]  = '{0, 32'h0000006A, 32'h00000004, 4'b1000, 32'h00000066, 1'b0};
        vt[2]  = '{1, 32'h0000006A, 32'h00000004, 4'b0001, 32'h000006A0, 1'b0};
        vt[3]  = '{1, 32'hAAAAAAAA, 32'hCCCCCCCC, 4'b1101, 32'hFFFAAAAA, 1'b0};
        vt[4]  = '{0, 32'hAAAAAAAA, 32'hCCCCCCCC, 4'b0101, 32'h000AAAAA, 1'b0};
        vt[5]  = '{1, 32'hFFFFFFFF, 32'h00000001, 4'b0010, 32'h00000001, 1'b0};
        vt[6]  = '{0, 32'hFFFFFFFF, 32'h00000001, 4'b0011, 32'h00000000, 1'b0};
        vt[7]  = '{1, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0111, 32'hF000F000, 1'b0};
        vt[8]  = '{0, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0110, 32'hFFF0FFF0, 1'b0};
        vt[9]  = '{0, 32'h12345678, 32'h00000001, 4'b1111, 32'h00000000, 1'b1};
        vt[10] = '{0, 32'h0000FFFF, 32'h01F80004, 4'b0100, 32'h01F8FFFB, 1'b0};
        vt[11] = '{1, 32'h00000005, 32'h00000006, 4'b1001, 32'h00000000, 1'b1};
        vt[12] = '{0, 32'h00000000, 32'h00000001, 4'b1000, 32'hFFFFFFFF, 1'b0};
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1, 0, 1};
`endif

        // Reset values, with both requesters already asking.
        req_a = '0; req_b = '0; req_op = '0;
        rsp_ready = 1'b0;
        set_ops(0, 32'h6A, 32'h4, 4'b1000);
        set_ops(1, 32'h6A, 32'h4, 4'b0001);
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", W'(req_ready), 0);
        chk("rst_rsp_valid", W'(rsp_valid), 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_op", W'(alu_op), 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id_err", W'({rsp_id, rsp_err}), 0);

        // Contention from reset: requester 0 first, then 1 back-to-back.
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("cont_grant0", W'(req_ready), 2'b01);
        tick();
        req_valid = 2'b10;
        @(negedge clk);
        chk("cont_exec_ready", W'(req_ready), 0);
        tick();
        @(negedge clk);
        chk("cont_rsp0_valid", W'(rsp_valid), 1);
        chk("cont_rsp0_data", rsp_data, 32'h66);
        chk("cont_rsp0_id", W'(rsp_id), 0);
        chk("cont_grant1", W'(req_ready), 2'b10);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("cont_exec2_ready", W'(req_ready), 0);
        tick();
        @(negedge clk);
        chk("cont_rsp1_valid", W'(rsp_valid), 1);
        chk("cont_rsp1_data", rsp_data, 32'h6A0);
        chk("cont_rsp1_id", W'(rsp_id), 1);
        tick();
        @(negedge clk);
        chk("cont_idle_valid", W'(rsp_valid), 0);
        tick();

        // Fairness: both held valid for six grants.
        set_ops(0, 32'h1, 32'h2, 4'b0000);
        set_ops(1, 32'h3, 32'h4, 4'b0000);
        req_valid = 2'b11;
        n_g = 0;
        got_g = '{-1, -1, -1, -1, -1, -1};
        for (int c = 0; c < 60 && n_g < 6; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                got_g[n_g] = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : 9;
                n_g++;
            end
            tick();
            if (n_g == 6) req_valid = '0;
        end
        req_valid = '0;
        for (int k = 0; k < 6; k++) chk($sformatf("fair_grant%0d", k), W'(got_g[k]), W'(exp_g[k]));
        repeat (4) tick();

        // Back-pressure on a held response, then same-cycle acceptance on release.
        rsp_ready = 1'b0;
        set_ops(1, 32'hAAAAAAAA, 32'hCCCCCCCC, 4'b1101);
        req_valid = 2'b10;
        @(negedge clk);
        chk("bp_grant1", W'(req_ready), 2'b10);
        tick();
        set_ops(0, 32'h0000FFFF, 32'h01F80004, 4'b0100);
        req_valid = 2'b01;
        @(negedge clk);
        chk("bp_exec_ready", W'(req_ready), 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge clk);
            chk($sformatf("bp_hold%0d_valid", c), W'(rsp_valid), 1);
            chk($sformatf("bp_hold%0d_data", c), rsp_data, 32'hFFFAAAAA);
            chk($sformatf("bp_hold%0d_ready", c), W'(req_ready), 0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_same_cycle_grant", W'(req_ready), 2'b01);
        chk("bp_release_id", W'(rsp_id), 1);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("bp_exec2_ready", W'(req_ready), 0);
        tick();
        @(negedge clk);
        chk("bp_rsp2_valid", W'(rsp_valid), 1);
        chk("bp_rsp2_data", rsp_data, 32'h01F8FFFB);
        chk("bp_rsp2_id_err", W'({rsp_id, rsp_err}), 0);
        tick();
        @(negedge clk);
        chk("bp_idle_valid", W'(rsp_valid), 0);
        tick();
        rsp_ready = 1'b0;

        for (int v = 0; v < 13; v++) begin
            do_single($sformatf("vec%0d", v), vt[v].id, vt[v].a, vt[v].b, vt[v].op,
                      vt[v].exp_d, vt[v].exp_e);
        end

        // Reset while an op sits in EXEC.
        set_ops(0, 32'h10, 32'h3, 4'b1000);
        req_valid = 2'b01;
        @(negedge clk);
        chk("rx_grant0", W'(req_ready), 2'b01);
        tick();
        req_valid = 2'b11;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rx_rsp_valid", W'(rsp_valid), 0);
        chk("rx_alu_op", W'(alu_op), 0);
        chk("rx_alu_a", alu_a, 0);
        chk("rx_req_ready", W'(req_ready), 0);
        tick();
        chk("rx_hold_valid", W'(rsp_valid), 0);
        req_valid = '0;
        rst_n = 1'b1;
        tick();
        do_single("rx_req1", 1, 32'h00000100, 32'h00000023, 4'b0000, 32'h00000123, 1'b0);

        // Randomized run against the reference, starting from a fresh reset.
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        m_exec = 1'b0; m_hold = 1'b0; m_vld = 1'b0;
        m_last = NREQ - 1;
        m_acc = '0;
        m_ca = '0; m_cb = '0; m_cop = '0; m_data = '0;
        m_cid = 0; m_id = 0; m_cerr = 1'b0; m_err = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rv = req_valid;
            for (int i = 0; i < NREQ; i++) begin
                if (m_acc[i] || !rv[i]) begin
                    rv[i] = ($urandom % 8) < 5;
                    req_a[i*W +: W] = $urandom;
                    req_b[i*W +: W] = ($urandom % 2 == 0) ? W'($urandom % 40) : W'($urandom);
                    req_op[i*4 +: 4] = ($urandom % 8 == 0) ? 4'($urandom) : legal_ops[$urandom % 10];
                end else if ($urandom % 16 == 0) begin
                    rv[i] = 1'b0;
                end
            end
            req_valid = rv;
            rsp_ready = ($urandom % 4) != 0;
            @(negedge clk);
            model_step();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
